// File: rtl/router_fifo_if.sv
// Handshake and data bundle between one router output port buffer and its writer/reader.
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty
  );
endinterface

// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router: header-tagged FIFO that tracks the
// remaining length of the packet being read and idles its output between packets.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  router_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = WIDTH - 1;

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             full, empty;
  logic             wr_acc, rd_acc, flush;
  logic [WIDTH:0]   rd_entry;

  // Header length field counts payload bytes; one more covers the parity byte.
  function automatic logic [CW-1:0] hdr_count(input logic [WIDTH-1:0] hdr);
    return {1'b0, hdr[WIDTH-1:2]} + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    return p + {{AW{1'b0}}, 1'b1};
  endfunction

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign flush    = reset || bus.soft_reset;
  assign wr_acc   = bus.write_enb && !full;
  assign rd_acc   = bus.read_enb && !empty;
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) begin
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        data_out_d = rd_entry[WIDTH-1:0];
        if (rd_entry[WIDTH])
          pkt_cnt_d = hdr_count(rd_entry[WIDTH-1:0]);
        else if (pkt_cnt_q != '0)
          pkt_cnt_d = pkt_cnt_q - {{(CW-1){1'b0}}, 1'b1};
      end else if (pkt_cnt_q == '0) begin
        data_out_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    pkt_cnt_q  <= pkt_cnt_d;
    data_out_q <= data_out_d;
  end

  // Storage is never cleared; a flush only rewinds the pointers.
  always_ff @(posedge clock) begin
    if (wr_acc && !flush)
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
  end

  assign bus.data_out = data_out_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
endmodule

// File: tb/tb_router_fifo.sv
// Randomised and directed bench for router_fifo against a queue-based packet model.
module tb_router_fifo;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [8:0] m_q[$];
  logic [7:0] m_dout;
  int         m_pkt;
  int         m_wr_cnt;
  int         m_rd_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [8:0] e;
    bit rd, wr;
    if (reset || bus.soft_reset) begin
      m_q.delete();
      m_dout = 8'h00; m_pkt = 0; m_wr_cnt = 0; m_rd_cnt = 0;
      return;
    end
    rd = bus.read_enb && (m_q.size() != 0);
    wr = bus.write_enb && (m_q.size() != 16);
    if (rd) begin
      e = m_q.pop_front();
      m_dout = e[7:0];
      m_rd_cnt = (m_rd_cnt + 1) % 32;
      if (e[8]) m_pkt = int'(e[7:2]) + 1;
      else if (m_pkt != 0) m_pkt = m_pkt - 1;
    end else if (m_pkt == 0) begin
      m_dout = 8'h00;
    end
    if (wr) begin
      m_q.push_back({bus.lfd_state, bus.data_in});
      m_wr_cnt = (m_wr_cnt + 1) % 32;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("data_out", 32'(bus.data_out), 32'(m_dout));
    check("empty", 32'(bus.empty), 32'(m_q.size() == 0));
    check("full", 32'(bus.full), 32'(m_q.size() == 16));
    check("pkt_cnt", 32'(dut.pkt_cnt_q), 32'(m_pkt));
    check("wr_ptr", 32'(dut.wr_ptr_q), 32'(m_wr_cnt));
    check("rd_ptr", 32'(dut.rd_ptr_q), 32'(m_rd_cnt));
  endtask

  task automatic drive(input bit we, input bit re, input bit lfd, input logic [7:0] d);
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.lfd_state = lfd;
    bus.data_in   = d;
  endtask

  task automatic wr_byte(input bit lfd, input logic [7:0] d);
    drive(1'b1, 1'b0, lfd, d);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [7:0] pkt1 [5];

  initial begin
    checks = 0; errors = 0;
    m_dout = 8'h00; m_pkt = 0; m_wr_cnt = 0; m_rd_cnt = 0;
    reset = 1'b1;
    bus.soft_reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    check("rst_dout", 32'(bus.data_out), 32'h00);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    reset = 1'b0;

    // Basic packet: header, three payload bytes, parity.
    pkt1[0] = 8'h0D; pkt1[1] = 8'hA1; pkt1[2] = 8'hA2; pkt1[3] = 8'hA3; pkt1[4] = 8'h5E;
    for (int i = 0; i < 5; i++) wr_byte(i == 0, pkt1[i]);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      tick();
      check("pkt1_data", 32'(bus.data_out), 32'(pkt1[i]));
      if (i == 0) check("pkt1_hdr_cnt", 32'(dut.pkt_cnt_q), 32'd4);
    end
    check("pkt1_end_cnt", 32'(dut.pkt_cnt_q), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check("pkt1_idle", 32'(bus.data_out), 32'h00);
    check("pkt1_empty", 32'(bus.empty), 32'd1);

    // Fill to full with write pointer wrap, drop a write, then drain.
    do_reset();
    for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'h10 + 8'(i));
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_wrptr", 32'(dut.wr_ptr_q), 32'd16);
    wr_byte(1'b0, 8'hFF);
    check("drop_wrptr", 32'(dut.wr_ptr_q), 32'd16);
    drive(1'b1, 1'b1, 1'b0, 8'hEE);
    tick();
    check("full_rw_full", 32'(bus.full), 32'd0);
    check("full_rw_data", 32'(bus.data_out), 32'h10);
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      tick();
      check("drain_data", 32'(bus.data_out), 32'(8'h10 + 8'(i)));
    end
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Occupancy-one simultaneous read and write.
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    wr_byte(1'b0, 8'h77);
    drive(1'b1, 1'b1, 1'b0, 8'h88);
    tick();
    check("occ1_data", 32'(bus.data_out), 32'h77);
    check("occ1_empty", 32'(bus.empty), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check("occ1_next", 32'(bus.data_out), 32'h88);

    // Soft reset mid-packet.
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    wr_byte(1'b1, 8'h21);
    for (int i = 0; i < 9; i++) wr_byte(1'b0, 8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      tick();
    end
    check("mid_cnt", 32'(dut.pkt_cnt_q), 32'd6);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    bus.soft_reset = 1'b1;
    tick();
    bus.soft_reset = 1'b0;
    check("srst_empty", 32'(bus.empty), 32'd1);
    check("srst_dout", 32'(bus.data_out), 32'h00);
    check("srst_cnt", 32'(dut.pkt_cnt_q), 32'd0);
    wr_byte(1'b1, 8'h09);
    wr_byte(1'b0, 8'h31);
    wr_byte(1'b0, 8'h32);
    wr_byte(1'b0, 8'h63);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check("pkt2_hdr", 32'(bus.data_out), 32'h09);
    check("pkt2_cnt", 32'(dut.pkt_cnt_q), 32'd3);
    for (int i = 0; i < 3; i++) tick();
    check("pkt2_par", 32'(bus.data_out), 32'h63);

    // Read while empty, then reset colliding with a write.
    tick();
    check("rdempty_rdptr", 32'(dut.rd_ptr_q), 32'd4);
    check("rdempty_dout", 32'(bus.data_out), 32'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h55);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_wr_empty", 32'(bus.empty), 32'd1);

    // Random traffic with occasional headers and flushes.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 7) == 0), 8'($urandom));
      bus.soft_reset = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    bus.soft_reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
